// File: rtl/seq_mult_param.sv
// seq_mult_param: shift-add multiplier with signed/unsigned mode, early exit, and a held result
module seq_mult_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     opA,
    input  logic [WIDTH-1:0]     opB,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic [CNT_W-1:0]     cycles
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;
    logic [2*WIDTH-1:0] acc, a_sh, acc_next;
    logic [WIDTH-1:0]   b_sh, mag_a, mag_b;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               neg, last, accept;
    // Operand magnitudes, next iteration values, and the early-exit condition
    always_comb begin
        mag_a    = (is_signed && opA[WIDTH-1]) ? -opA : opA;
        mag_b    = (is_signed && opB[WIDTH-1]) ? -opB : opB;
        acc_next = acc + (b_sh[0] ? a_sh : '0);
        cnt_next = cnt + CNT_W'(1);
        last     = (b_sh[WIDTH-1:1] == '0) || (cnt_next == CNT_W'(WIDTH));
        accept   = start && (state != RUN);
    end
    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end
    // Next state and status flags; a start from DONE goes straight back to RUN
    always_comb begin
        state_next = accept ? RUN : ((state == RUN) && last) ? DONE : state;
        busy       = (state == RUN);
        done       = (state == DONE);
    end
    // Datapath: latch magnitudes on start, shift-add while running, publish on the last iteration
    always_ff @(posedge clk) begin
        if (reset) begin
            acc    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            cnt    <= '0;
            neg    <= 1'b0;
            result <= '0;
            cycles <= '0;
        end else if (accept) begin
            acc    <= '0;
            a_sh   <= {{WIDTH{1'b0}}, mag_a};
            b_sh   <= mag_b;
            cnt    <= '0;
            neg    <= is_signed && (opA[WIDTH-1] ^ opB[WIDTH-1]);
        end else if (state == RUN) begin
            acc    <= acc_next;
            a_sh   <= a_sh << 1;
            b_sh   <= b_sh >> 1;
            cnt    <= cnt_next;
            if (last) begin
                result <= neg ? -acc_next : acc_next;
                cycles <= cnt_next;
            end
        end
    end
endmodule

// File: tb/tb_seq_mult_param.sv
// tb_seq_mult_param: randomized and directed checks of seq_mult_param at WIDTH=32 and WIDTH=8
module tb_seq_mult_param;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        start32 = 1'b0, sgn32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [63:0] res32;
    logic [5:0]  cyc32;

    logic        start8 = 1'b0, sgn8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] res8;
    logic [3:0]  cyc8;

    int total = 0;
    int passed = 0;

    seq_mult_param #(.WIDTH(32), .CNT_W(6)) dut32 (
        .clk(clk), .reset(reset), .start(start32), .is_signed(sgn32),
        .opA(a32), .opB(b32), .busy(busy32), .done(done32),
        .result(res32), .cycles(cyc32)
    );

    seq_mult_param #(.WIDTH(8), .CNT_W(4)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .is_signed(sgn8),
        .opA(a8), .opB(b8), .busy(busy8), .done(done8),
        .result(res8), .cycles(cyc8)
    );

    // Exact product of two w-bit operands, reduced to 2w bits
    function automatic logic [63:0] ref_prod(int w, bit sgn, logic [31:0] a, logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = {32'd0, a};
        eb = {32'd0, b};
        if (sgn && a[w-1]) ea = ea | (~64'd0 << w);
        if (sgn && b[w-1]) eb = eb | (~64'd0 << w);
        p = ea * eb;
        return (w == 32) ? p : (p & ((64'd1 << (2 * w)) - 64'd1));
    endfunction

    // Iterations = position of the highest set bit of |b| plus one, at least one
    function automatic int ref_cycles(int w, bit sgn, logic [31:0] b);
        logic [32:0] mag;
        int n;
        mag = (sgn && b[w-1]) ? ((33'd1 << w) - {1'b0, b}) : {1'b0, b};
        n = 1;
        for (int i = 0; i < w; i++) if (mag[i]) n = i + 1;
        return n;
    endfunction

    // Issue one operation and wait (bounded) for done; reports status seen right after the start edge
    task automatic do_op(input int w, input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int cyc, output int lat,
                         output logic busy0, output logic done0);
        @(negedge clk);
        if (w == 32) begin
            start32 = 1'b1; sgn32 = sgn; a32 = a; b32 = b;
        end else begin
            start8 = 1'b1; sgn8 = sgn; a8 = a[7:0]; b8 = b[7:0];
        end
        @(negedge clk);
        start32 = 1'b0;
        start8 = 1'b0;
        busy0 = (w == 32) ? busy32 : busy8;
        done0 = (w == 32) ? done32 : done8;
        lat = 0;
        while (((w == 32) ? done32 : done8) !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = (w == 32) ? res32 : {48'd0, res8};
        cyc = (w == 32) ? int'(cyc32) : int'(cyc8);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        total++; if ({busy32, done32} !== 2'b00) $display("FAIL reset32_flags got %b want 00", {busy32, done32}); else passed++;
        total++; if (res32 !== 64'd0 || cyc32 !== 6'd0) $display("FAIL reset32_data got %h/%0d want 0/0", res32, cyc32); else passed++;
        total++; if ({busy8, done8} !== 2'b00) $display("FAIL reset8_flags got %b want 00", {busy8, done8}); else passed++;
        total++; if (res8 !== 16'd0 || cyc8 !== 4'd0) $display("FAIL reset8_data got %h/%0d want 0/0", res8, cyc8); else passed++;
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [63:0] res;
        int cyc, lat;
        logic b0, d0;
        bit          sg  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        logic [31:0] ta  [6] = '{32'd1, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h80000000};
        logic [31:0] tb  [6] = '{32'd1, 32'hFFFFFFFF, 32'd5, 32'd5, 32'h80000000, 32'd1};
        logic [63:0] er  [6] = '{64'd1, 64'h00000006FFFFFFF9, 64'hFFFFFFFFFFFFFFF1,
                                 64'h00000004FFFFFFF1, 64'h4000000000000000, 64'hFFFFFFFF80000000};
        int          ec  [6] = '{1, 32, 3, 3, 32, 1};
        for (int i = 0; i < 6; i++) begin
            do_op(32, sg[i], ta[i], tb[i], res, cyc, lat, b0, d0);
            total++; if (b0 !== 1'b1 || d0 !== 1'b0) $display("FAIL dir%0d_busy got busy=%b done=%b want 1/0", i, b0, d0); else passed++;
            total++; if (res !== er[i]) $display("FAIL dir%0d_result got %h want %h", i, res, er[i]); else passed++;
            total++; if (cyc !== ec[i]) $display("FAIL dir%0d_cycles got %0d want %0d", i, cyc, ec[i]); else passed++;
            total++; if (lat !== ec[i]) $display("FAIL dir%0d_latency got %0d want %0d", i, lat, ec[i]); else passed++;
        end
    endtask

    task automatic test_hold();
        logic [63:0] res;
        int cyc, lat;
        logic b0, d0;
        do_op(32, 1'b0, 32'h1234, 32'h55, res, cyc, lat, b0, d0);
        for (int i = 0; i < 5; i++) begin
            a32 = $urandom; b32 = $urandom; sgn32 = 1'(i);
            @(negedge clk);
            total++; if (done32 !== 1'b1 || busy32 !== 1'b0) $display("FAIL hold_flags got done=%b busy=%b want 1/0", done32, busy32); else passed++;
            total++; if (res32 !== 64'h1234 * 64'h55) $display("FAIL hold_result got %h want %h", res32, 64'h1234 * 64'h55); else passed++;
        end
    endtask

    task automatic test_start_during_run();
        int lat;
        logic [63:0] exp_res;
        exp_res = ref_prod(32, 1'b0, 32'h1234, 32'hF0000000);
        @(negedge clk);
        start32 = 1'b1; sgn32 = 1'b0; a32 = 32'h1234; b32 = 32'hF0000000;
        @(negedge clk);
        lat = 0;
        for (int i = 0; i < 10; i++) begin
            start32 = ~start32; a32 = $urandom; b32 = $urandom; sgn32 = $urandom;
            @(negedge clk);
            lat++;
        end
        start32 = 1'b0;
        while (done32 !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        total++; if (res32 !== exp_res) $display("FAIL run_ignore_result got %h want %h", res32, exp_res); else passed++;
        total++; if (cyc32 !== 6'd32 || lat !== 32) $display("FAIL run_ignore_cycles got %0d/%0d want 32/32", cyc32, lat); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int cyc, lat;
        logic b0, d0;
        do_op(32, 1'b0, 32'd9, 32'd9, res, cyc, lat, b0, d0);
        do_op(32, 1'b0, 32'd2, 32'd3, res, cyc, lat, b0, d0);
        total++; if (d0 !== 1'b0 || b0 !== 1'b1) $display("FAIL b2b_done_drop got done=%b busy=%b want 0/1", d0, b0); else passed++;
        total++; if (lat !== 2 || cyc !== 2) $display("FAIL b2b_latency got %0d/%0d want 2/2", lat, cyc); else passed++;
        total++; if (res !== 64'd6) $display("FAIL b2b_result got %h want 6", res); else passed++;
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        start32 = 1'b1; sgn32 = 1'b0; a32 = 32'd5; b32 = 32'hFFFFFFFF;
        @(negedge clk);
        start32 = 1'b0;
        repeat (4) @(negedge clk);
        total++; if (busy32 !== 1'b1) $display("FAIL abort_pre_busy got %b want 1", busy32); else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++; if ({busy32, done32} !== 2'b00 || res32 !== 64'd0 || cyc32 !== 6'd0)
            $display("FAIL abort_state got busy=%b done=%b res=%h cyc=%0d want 0/0/0/0", busy32, done32, res32, cyc32); else passed++;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if ({busy32, done32} !== 2'b00) $display("FAIL abort_idle got busy=%b done=%b want 0/0", busy32, done32); else passed++;
    endtask

    task automatic test_random(input int w, input int n);
        logic [63:0] res, exp_res;
        logic [31:0] mask, a, b;
        int cyc, lat, exp_cyc, pick;
        logic b0, d0;
        bit sgn;
        mask = (w == 32) ? 32'hFFFFFFFF : 32'hFF;
        for (int i = 0; i < n; i++) begin
            a = $urandom & mask;
            b = ($urandom & mask) >> $urandom_range(0, w - 1);
            sgn = 1'($urandom);
            pick = $urandom_range(0, 9);
            if (pick == 0) a = 32'd0;
            if (pick == 1) b = 32'd0;
            if (pick == 2) a = 32'd1 << (w - 1);
            if (pick == 3) b = 32'd1 << (w - 1);
            if (pick == 4) b = b | (32'd1 << (w - 1));
            exp_res = ref_prod(w, sgn, a, b);
            exp_cyc = ref_cycles(w, sgn, b);
            do_op(w, sgn, a, b, res, cyc, lat, b0, d0);
            total++; if (res !== exp_res) $display("FAIL rand%0d_result s=%0d a=%h b=%h got %h want %h", w, sgn, a, b, res, exp_res); else passed++;
            total++; if (cyc !== exp_cyc) $display("FAIL rand%0d_cycles s=%0d b=%h got %0d want %0d", w, sgn, b, cyc, exp_cyc); else passed++;
            total++; if (lat !== exp_cyc) $display("FAIL rand%0d_latency s=%0d b=%h got %0d want %0d", w, sgn, b, lat, exp_cyc); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_start_during_run();
        test_back_to_back();
        test_reset_mid_run();
        test_random(8, 2000);
        test_random(32, 800);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
